// File: rtl/blinky_key_pio_in_pkg.sv
// Shared register map, edge-type encodings and edge selection helper for the key PIO.
package blinky_key_pio_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Edge pulses from current/previous debounced level; 32 bits wide so any WIDTH fits.
  function automatic logic [31:0] edge_sel(input logic [31:0] cur,
                                           input logic [31:0] prev,
                                           input int          etype);
    logic [31:0] e;
    case (etype)
      EDGE_FALL: e = ~cur & prev;
      EDGE_ANY:  e = cur ^ prev;
      default:   e = cur & ~prev;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/blinky_key_pio_in_if.sv
// Avalon-MM slave bus bundle for the key PIO (read latency 0).
interface blinky_key_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/blinky_pio_debounce.sv
// One pin: 2-flop synchroniser followed by a stable-time debouncer.
module blinky_pio_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din_async,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYC);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign cnt_nxt = cnt + 1'b1;

  // Sync the pin; accept a new level once it has differed for DEBOUNCE_CYC consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= din_async;
      s2 <= s1;
      if (s2 != level) begin
        if (cnt_nxt == LIMIT) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt_nxt;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/blinky_key_pio_in.sv
// Input PIO: debounced pins, edge capture with W1C, interrupt mask and level IRQ.
module blinky_key_pio_in
  import blinky_key_pio_in_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int EDGE_TYPE    = EDGE_RISE
) (
  input  logic                 clk,
  input  logic                 reset,
  blinky_key_pio_in_if.slave   bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev_level;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             unused_wdata;

  blinky_pio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db [WIDTH-1:0] (
    .clk       (clk),
    .reset     (reset),
    .din_async (in_port),
    .level     (level)
  );

  assign wr           = bus.chipselect && !bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;
  assign edge_det     = WIDTH'(edge_sel(32'(level), 32'(prev_level), EDGE_TYPE));
  assign clr          = (wr && bus.address == ADDR_EDGECAP) ? wdata : '0;

  // Edge history, capture (a new edge beats a same-cycle clear), mask and IRQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_level  <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
      irq         <= 1'b0;
    end else begin
      prev_level  <= level;
      edgecapture <= (edgecapture & ~clr) | edge_det;
      if (wr && bus.address == ADDR_IRQMASK) irqmask <= wdata;
      irq <= |(edgecapture & irqmask);
    end
  end

  // Zero-latency read mux, upper bits zero-extended; chipselect not required.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata[WIDTH-1:0] = level;
      ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edgecapture;
      default:      bus.readdata = '0;
    endcase
  end

endmodule
